// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-cycle memory port.
// Define ARB_STARVE_GUARD_EN to add the fetch starvation guard (forced fetch after STARVE_MAX denials).
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e            owner_q, owner_d;
    logic              force_if;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    // Counts every cycle fetch is requesting but not granted, including enable-low cycles.
    always_comb begin
        starve_d = starve_q;
        if (if_gnt) begin
            starve_d = '0;
        end else if (if_req && (starve_q != CNT_W'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign force_if = if_req && (starve_q == CNT_W'(STARVE_MAX));
`else
    assign force_if = 1'b0;
`endif

    // Data wins unless the starvation guard is forcing a fetch.
    assign d_gnt    = enable & d_req & ~force_if;
    assign if_gnt   = enable & if_req & ~d_gnt;
    assign stall_if = if_req & ~if_gnt;

    assign mem_req   = if_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = d_gnt ? d_addr : if_addr;
    assign mem_wdata = d_gnt ? d_wdata : '0;

    always_comb begin
        owner_d   = OWN_NONE;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if (d_gnt) begin
            owner_d = OWN_D;
        end else if (if_gnt) begin
            owner_d = OWN_IF;
        end
        case (owner_q)
            OWN_IF:  if_rvalid = 1'b1;
            OWN_D:   d_rvalid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Response data is passed through while valid and held afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_rvalid) begin
                if_rdata_q <= mem_rdata;
            end
            if (d_rvalid) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata  = d_rvalid  ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a cycle-level behavioural model.
// Build with or without ARB_STARVE_GUARD_EN; the model follows the same macro.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt, if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req = 1'b0, d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_gnt, d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              stall_if;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_if (stall_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: who is owed a response next cycle, fetch wait count, last delivered data.
    string             m_pend = "none";
    bit                m_pend_store = 1'b0;
    int                m_starve = 0;
    logic [DATA_W-1:0] m_last_if = '0;
    logic [DATA_W-1:0] m_last_d = '0;
    bit                m_last_d_known = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_pend         = "none";
        m_pend_store   = 1'b0;
        m_starve       = 0;
        m_last_if      = '0;
        m_last_d       = '0;
        m_last_d_known = 1'b1;
    endtask

    // Drives one cycle of inputs mid-cycle, checks all outputs against the model,
    // then advances the model to the next clock edge.
    task automatic step(input bit en, input bit ir, input logic [ADDR_W-1:0] ia,
                        input bit dr, input bit dwe, input logic [ADDR_W-1:0] da,
                        input logic [DATA_W-1:0] dwd, input logic [DATA_W-1:0] mrd);
        bit fetch_forced, exp_d, exp_if;
        @(negedge clk);
        enable = en; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        mem_rdata = mrd;
        #1;
        chk("if_rvalid", if_rvalid, m_pend == "if");
        chk("d_rvalid", d_rvalid, m_pend == "d");
        chk("if_rdata", if_rdata, (m_pend == "if") ? mrd : m_last_if);
        if (m_pend == "d" && !m_pend_store) chk("d_rdata_load", d_rdata, mrd);
        else if (m_pend != "d" && m_last_d_known) chk("d_rdata_hold", d_rdata, m_last_d);

        fetch_forced = GUARD && ir && (m_starve >= STARVE_MAX);
        exp_d  = en && dr && !fetch_forced;
        exp_if = en && ir && !exp_d;
        chk("d_gnt", d_gnt, exp_d);
        chk("if_gnt", if_gnt, exp_if);
        chk("mem_req", mem_req, exp_d || exp_if);
        chk("mem_we", mem_we, exp_d && dwe);
        chk("stall_if", stall_if, ir && !exp_if);
        if (exp_d) chk("mem_addr_d", mem_addr, da);
        if (exp_if) chk("mem_addr_if", mem_addr, ia);
        if (exp_d && dwe) chk("mem_wdata", mem_wdata, dwd);

        if (m_pend == "if") m_last_if = mrd;
        if (m_pend == "d") begin
            m_last_d       = mrd;
            m_last_d_known = !m_pend_store;
        end
        m_pend       = exp_d ? "d" : (exp_if ? "if" : "none");
        m_pend_store = dwe;
        if (exp_if) m_starve = 0;
        else if (ir && m_starve < STARVE_MAX) m_starve++;
    endtask

    task automatic idle(input logic [DATA_W-1:0] mrd);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, mrd);
    endtask

    initial begin
        // Reset with no requests: everything quiet.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_rvalid", if_rvalid, 1'b0);
        chk("rst_d_rvalid", d_rvalid, 1'b0);
        chk("rst_if_rdata", if_rdata, '0);
        chk("rst_d_rdata", d_rdata, '0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        idle(32'h1111_2222);
        chk("idle_if_gnt", if_gnt, 1'b0);
        chk("idle_d_gnt", d_gnt, 1'b0);
        chk("idle_mem_req", mem_req, 1'b0);
        chk("idle_rvalid", if_rvalid | d_rvalid, 1'b0);

        // Lone fetch: grant and address now, data next cycle.
        step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, '0, '0, 32'h0);
        chk("f_gnt", if_gnt, 1'b1);
        chk("f_addr", mem_addr, 32'h10);
        idle(32'hCAFE_F00D);
        chk("f_rvalid", if_rvalid, 1'b1);
        chk("f_rdata", if_rdata, 32'hCAFE_F00D);

        // Contention: store wins, fetch stalls, fetch granted while store completes.
        step(1'b1, 1'b1, 32'h20, 1'b1, 1'b1, 32'h40, 32'hA5, 32'h0);
        chk("c_d_gnt", d_gnt, 1'b1);
        chk("c_if_gnt", if_gnt, 1'b0);
        chk("c_mem_we", mem_we, 1'b1);
        chk("c_mem_addr", mem_addr, 32'h40);
        chk("c_mem_wdata", mem_wdata, 32'hA5);
        chk("c_stall", stall_if, 1'b1);
        step(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, '0, '0, 32'h0);
        chk("c_d_rvalid", d_rvalid, 1'b1);
        chk("c_if_gnt_next", if_gnt, 1'b1);
        chk("c_mem_we_fetch", mem_we, 1'b0);
        idle(32'h5);

        // Enable low with both requesting: no grants, fetch stalled.
        step(1'b0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h50, '0, 32'h0);
        chk("en0_if_gnt", if_gnt, 1'b0);
        chk("en0_d_gnt", d_gnt, 1'b0);
        chk("en0_mem_req", mem_req, 1'b0);
        chk("en0_stall", stall_if, 1'b1);

        // Continuous contention from a cleared wait count.
        step(1'b1, 1'b1, 32'h34, 1'b0, 1'b0, '0, '0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 32'h38, 1'b1, 1'b0, 32'h60, '0, $urandom);
            chk("starve_pattern", d_gnt, GUARD ? ((i % 5) != 4) : 1'b1);
        end
        idle($urandom);

        // Reset in the cycle after a fetch grant drops the response.
        step(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, '0, '0, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        if_req = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rstmid_if_rvalid", if_rvalid, 1'b0);
        chk("rstmid_if_rdata", if_rdata, '0);
        chk("rstmid_mem_req", mem_req, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        idle(32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, $urandom);
        end
        idle($urandom);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
